bulk_in_packetiser: RTL and testbench

Bulk-IN packetiser sitting directly downstream of the telemetry (and other bulk) endpoint sources. It accepts an AXI-style byte stream, fills a single-packet buffer up to the maximum packet size or the end of a transfer, and presents the packet to the USB transmitter when the host issues an IN token. The buffered packet is held until the host ACKs it, so a lost handshake replays the same payload. It NAKs when no complete packet is ready.

---
 rtl/usb_bulk_pkg.sv | 16 +
 rtl/bulk_in_packetiser_if.sv | 32 +++
 rtl/bulk_pkt_ram.sv | 30 +++
 rtl/bulk_in_packetiser.sv | 189 ++++++++++++++++++
 tb/tb_bulk_in_packetiser.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_bulk_pkg.sv
// Shared definitions for the bulk endpoint datapath: FSM state encoding and
// the standard maximum packet sizes for high-speed and full-speed bulk pipes.
package usb_bulk_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned MAX_PACKET_HS = 512;
  localparam int unsigned MAX_PACKET_FS = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/bulk_in_packetiser_if.sv
// Stream, token and handshake signals between the bulk-IN packetiser and its
// neighbours. The master modport is the packetiser's own view.
interface bulk_in_packetiser_if;

  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] s_tdata;

  logic       tx_start_i;
  logic       ack_i;
  logic       timeout_i;
  logic       tx_nak_o;
  logic       pkt_ready_o;

  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       m_tkeep;
  logic [7:0] m_tdata;

  modport master (
    input  s_tvalid, s_tlast, s_tdata, tx_start_i, ack_i, timeout_i, m_tready,
    output s_tready, tx_nak_o, pkt_ready_o, m_tvalid, m_tlast, m_tkeep, m_tdata
  );

  modport slave (
    output s_tvalid, s_tlast, s_tdata, tx_start_i, ack_i, timeout_i, m_tready,
    input  s_tready, tx_nak_o, pkt_ready_o, m_tvalid, m_tlast, m_tkeep, m_tdata
  );

endinterface

// File: rtl/bulk_pkt_ram.sv
// Single-packet buffer: simple dual-port 2^ABITS x 8 RAM, one write port and
// one read port with a registered read that only updates when enabled.
module bulk_pkt_ram #(
  parameter int unsigned ABITS = 9
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [ABITS-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic             i_re,
  input  logic [ABITS-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [0:(1<<ABITS)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // Holding rdata while disabled lets the read stage act as a pipeline slot.
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bulk_in_packetiser.sv
// Bulk-IN packetiser: buffers one packet from a byte stream and replays it on
// IN tokens until ACKed. Define BULK_IN_ZLP_EN to emit ZLPs after full transfers.
module bulk_in_packetiser
  import usb_bulk_pkg::*;
#(
  parameter int unsigned MAX_PACKET = MAX_PACKET_HS,
  parameter int unsigned ABITS      = 9
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bulk_in_packetiser_if.master bus
);

  localparam logic [ABITS:0] LEN_MAX = (ABITS+1)'(MAX_PACKET);
  localparam logic [ABITS:0] LEN_ONE = (ABITS+1)'(1);

  state_e         r_state;
  state_e         w_state_d;
  logic [ABITS:0] r_len;
  logic [ABITS:0] r_rd_addr;
  logic           r_nak;

  logic           r_rd_valid;
  logic           r_rd_last;
  logic           r_out_valid;
  logic           r_out_last;
  logic [7:0]     r_out_data;

  logic           w_s_tready;
  logic           w_s_fire;
  logic           w_m_fire;
  logic [ABITS:0] w_len_inc;
  logic           w_pkt_done;
  logic           w_ack;
  logic           w_timeout;
  logic           w_zlp_pend;
  logic           w_more;
  logic           w_re;
  logic [ABITS:0] w_rd_idx;
  logic [ABITS:0] w_rd_idx_p1;
  logic           w_rd_last_d;
  logic           w_rd_keep;
  logic           w_load;
  logic [7:0]     w_rdata;

  assign w_s_tready = (r_state == ST_FILL);
  assign w_s_fire   = bus.s_tvalid && w_s_tready;
  assign w_m_fire   = r_out_valid && bus.m_tready;
  assign w_len_inc  = r_len + LEN_ONE;
  assign w_pkt_done = w_s_fire && ((w_len_inc == LEN_MAX) || bus.s_tlast);
  assign w_ack      = (r_state == ST_WAIT) && bus.ack_i;
  assign w_timeout  = (r_state == ST_WAIT) && bus.timeout_i;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_FILL: begin
        if (w_pkt_done) begin
          w_state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.tx_start_i) begin
          w_state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_m_fire && r_out_last) begin
          w_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A non-empty ACKed packet with a ZLP owed goes back to READY with len 0.
        if (w_ack) begin
          w_state_d = (w_zlp_pend && (r_len != '0)) ? ST_READY : ST_FILL;
        end else if (w_timeout) begin
          w_state_d = ST_READY;
        end
      end
      default: w_state_d = ST_FILL;
    endcase
  end

  // Read issue: the token itself reads address 0 so the first beat lands two
  // cycles later; afterwards reads refill the read stage as the output drains.
  assign w_more      = (r_rd_addr < r_len);
  assign w_load      = r_rd_valid && (!r_out_valid || bus.m_tready);
  assign w_re        = ((r_state == ST_READY) && bus.tx_start_i) ||
                       ((r_state == ST_SEND) && w_more && (!r_rd_valid || w_load));
  assign w_rd_idx    = (r_state == ST_READY) ? '0 : r_rd_addr;
  assign w_rd_idx_p1 = w_rd_idx + LEN_ONE;
  assign w_rd_last_d = (w_rd_idx_p1 >= r_len);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_len       <= '0;
      r_rd_addr   <= '0;
      r_nak       <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_nak   <= (r_state == ST_FILL) && bus.tx_start_i;

      if (w_s_fire) begin
        r_len <= w_len_inc;
      end else if (w_ack) begin
        r_len <= '0;
      end

      if (w_re) begin
        r_rd_addr <= w_rd_idx_p1;
        r_rd_last <= w_rd_last_d;
      end

      if (w_re) begin
        r_rd_valid <= 1'b1;
      end else if (w_load) begin
        r_rd_valid <= 1'b0;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_last  <= r_rd_last;
        r_out_data  <= w_rd_keep ? w_rdata : 8'h00;
      end else if (bus.m_tready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef BULK_IN_ZLP_EN
  logic r_zlp_pend;
  logic r_rd_keep;
  logic r_out_keep;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_zlp_pend <= 1'b0;
      r_rd_keep  <= 1'b0;
      r_out_keep <= 1'b0;
    end else begin
      if (w_s_fire && bus.s_tlast && (w_len_inc == LEN_MAX)) begin
        r_zlp_pend <= 1'b1;
      end else if (w_ack && (r_len == '0)) begin
        r_zlp_pend <= 1'b0;
      end
      if (w_re) begin
        r_rd_keep <= (r_len != '0);
      end
      if (w_load) begin
        r_out_keep <= r_rd_keep;
      end
    end
  end

  assign w_zlp_pend  = r_zlp_pend;
  assign w_rd_keep   = r_rd_keep;
  assign bus.m_tkeep = r_out_keep;
`else
  assign w_zlp_pend  = 1'b0;
  assign w_rd_keep   = 1'b1;
  assign bus.m_tkeep = 1'b1;
`endif

  bulk_pkt_ram #(
    .ABITS (ABITS)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_s_fire),
    .i_waddr (r_len[ABITS-1:0]),
    .i_wdata (bus.s_tdata),
    .i_re    (w_re),
    .i_raddr (w_rd_idx[ABITS-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.s_tready    = w_s_tready;
  assign bus.pkt_ready_o = (r_state == ST_READY);
  assign bus.tx_nak_o    = r_nak;
  assign bus.m_tvalid    = r_out_valid;
  assign bus.m_tlast     = r_out_last;
  assign bus.m_tdata     = r_out_data;

endmodule

// File: tb/tb_bulk_in_packetiser.sv
// Directed bench for bulk_in_packetiser (MAX_PACKET=64): expected beats are
// queued when each IN token is issued and popped as the transmitter accepts them.
module tb_bulk_in_packetiser;

  localparam int unsigned MAXP  = 64;
  localparam int unsigned ABITS = 6;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       k;
  } beat_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  beat_t      sb[$];
  logic [7:0] cur_pkt[$];

  bulk_in_packetiser_if bus ();

  bulk_in_packetiser #(
    .MAX_PACKET (MAXP),
    .ABITS      (ABITS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Leaves the byte presented; it is taken at the following rising edge.
  task automatic push_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    @(posedge clock); #1;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    @(negedge clock);
    while (!bus.s_tready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check_b("src_accept", bus.s_tready, 1'b1);
    cur_pkt.push_back(d);
  endtask

  task automatic push_run(input logic [7:0] base, input int n, input logic last_on_end);
    logic [7:0] v = base;
    for (int i = 0; i < n; i++) begin
      push_byte(v, last_on_end && (i == n - 1));
      v = v + 8'd1;
    end
  endtask

  task automatic src_idle();
    @(posedge clock); #1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic drain(input bit stall);
    int         guard = 0;
    bit         held  = 1'b0;
    logic [7:0] hd;
    logic       hl;
    beat_t      e;
    while (sb.size() > 0 && guard < 2000) begin
      @(posedge clock); #1;
      bus.m_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clock);
      guard++;
      if (held) begin
        check_b("hold_valid", bus.m_tvalid, 1'b1);
        check_d("hold_data", bus.m_tdata, hd);
        check_b("hold_last", bus.m_tlast, hl);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        e = sb.pop_front();
        check_d("beat_data", bus.m_tdata, e.d);
        check_b("beat_last", bus.m_tlast, e.l);
        check_b("beat_keep", bus.m_tkeep, e.k);
        held = 1'b0;
      end else if (bus.m_tvalid) begin
        held = 1'b1;
        hd   = bus.m_tdata;
        hl   = bus.m_tlast;
      end else begin
        held = 1'b0;
      end
    end
    check_b("drain_done", sb.size() == 0, 1'b1);
    @(posedge clock); #1;
    bus.m_tready = 1'b0;
    @(negedge clock);
    check_b("drain_idle", bus.m_tvalid, 1'b0);
  endtask

  // IN token for a buffered packet: queue its beats, check first-beat latency, drain.
  task automatic token_pkt(input bit stall);
    if (cur_pkt.size() == 0) begin
      sb.push_back(beat_t'{d: 8'h00, l: 1'b1, k: 1'b0});
    end else begin
      for (int i = 0; i < cur_pkt.size(); i++) begin
        sb.push_back(beat_t'{d: cur_pkt[i], l: (i == cur_pkt.size() - 1), k: 1'b1});
      end
    end
    @(posedge clock); #1;
    bus.m_tready   = 1'b0;
    bus.tx_start_i = 1'b1;
    @(negedge clock);
    check_b("tok_lat0", bus.m_tvalid, 1'b0);
    @(posedge clock); #1;
    bus.tx_start_i = 1'b0;
    @(negedge clock);
    check_b("tok_lat1", bus.m_tvalid, 1'b0);
    check_b("tok_no_nak", bus.tx_nak_o, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    check_b("tok_lat2", bus.m_tvalid, 1'b1);
    drain(stall);
  endtask

  task automatic nak_token();
    @(posedge clock); #1;
    bus.tx_start_i = 1'b1;
    @(negedge clock);
    check_b("nak_early", bus.tx_nak_o, 1'b0);
    @(posedge clock); #1;
    bus.tx_start_i = 1'b0;
    @(negedge clock);
    check_b("nak_pulse", bus.tx_nak_o, 1'b1);
    @(negedge clock);
    check_b("nak_single", bus.tx_nak_o, 1'b0);
    check_b("nak_no_data", bus.m_tvalid, 1'b0);
  endtask

  task automatic handshake(input logic a, input logic t);
    @(posedge clock); #1;
    bus.ack_i     = a;
    bus.timeout_i = t;
    @(posedge clock); #1;
    bus.ack_i     = 1'b0;
    bus.timeout_i = 1'b0;
  endtask

  initial begin
    int guard;
    bus.s_tvalid   = 1'b0;
    bus.s_tlast    = 1'b0;
    bus.s_tdata    = 8'h00;
    bus.tx_start_i = 1'b0;
    bus.ack_i      = 1'b0;
    bus.timeout_i  = 1'b0;
    bus.m_tready   = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    check_b("rst_m_tvalid", bus.m_tvalid, 1'b0);
    check_b("rst_pkt_ready", bus.pkt_ready_o, 1'b0);
    check_b("rst_nak", bus.tx_nak_o, 1'b0);
    check_b("rst_m_tlast", bus.m_tlast, 1'b0);
    check_d("rst_m_tdata", bus.m_tdata, 8'h00);
`ifdef BULK_IN_ZLP_EN
    check_b("rst_m_tkeep", bus.m_tkeep, 1'b0);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_b("post_rst_s_tready", bus.s_tready, 1'b1);

    // 16-byte packet, then timeout and replay, then ACK
    push_run(8'h00, 16, 1'b1);
    check_b("pkt_ready_early", bus.pkt_ready_o, 1'b0);
    src_idle();
    @(negedge clock);
    check_b("pkt_ready_rise", bus.pkt_ready_o, 1'b1);
    check_b("ready_s_tready", bus.s_tready, 1'b0);
    token_pkt(1'b0);
    handshake(1'b0, 1'b1);
    @(negedge clock);
    check_b("replay_ready", bus.pkt_ready_o, 1'b1);
    token_pkt(1'b1);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();
    @(negedge clock);
    check_b("ack_fill", bus.s_tready, 1'b1);
    check_b("ack_not_ready", bus.pkt_ready_o, 1'b0);

    // NAK with 3 bytes buffered; handshakes outside WAIT ignored; ack beats timeout
    push_run(8'hA0, 3, 1'b0);
    src_idle();
    nak_token();
    push_byte(8'hA3, 1'b1);
    src_idle();
    handshake(1'b1, 1'b1);
    @(negedge clock);
    check_b("hs_ignored", bus.pkt_ready_o, 1'b1);
    token_pkt(1'b1);
    handshake(1'b1, 1'b1);
    cur_pkt.delete();
    @(negedge clock);
    check_b("ack_wins", bus.s_tready, 1'b1);
    nak_token();

    // Full packet ending in tlast
    push_run(8'h40, MAXP, 1'b1);
    src_idle();
    token_pkt(1'b0);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();
`ifdef BULK_IN_ZLP_EN
    @(negedge clock);
    check_b("zlp_ready", bus.pkt_ready_o, 1'b1);
    token_pkt(1'b0);
    handshake(1'b1, 1'b0);
`endif
    nak_token();

    // 130-byte transfer: 64, 64, 2
    push_run(8'h80, MAXP, 1'b0);
    src_idle();
    @(negedge clock);
    check_b("full_hold", bus.s_tready, 1'b0);
    token_pkt(1'b1);
    check_b("wait_hold", bus.s_tready, 1'b0);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();
    push_run(8'hC0, MAXP, 1'b0);
    src_idle();
    token_pkt(1'b0);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();
    push_run(8'h11, 2, 1'b1);
    src_idle();
    token_pkt(1'b0);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();
    @(negedge clock);
    check_b("no_zlp_short", bus.pkt_ready_o, 1'b0);
    nak_token();

    // Asynchronous reset while a beat is stalled on the output
    push_run(8'h50, 5, 1'b1);
    src_idle();
    @(posedge clock); #1;
    bus.m_tready   = 1'b0;
    bus.tx_start_i = 1'b1;
    @(posedge clock); #1;
    bus.tx_start_i = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!bus.m_tvalid && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    check_b("pre_reset_valid", bus.m_tvalid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_b("async_drop", bus.m_tvalid, 1'b0);
    check_b("async_pkt_ready", bus.pkt_ready_o, 1'b0);
    cur_pkt.delete();
    sb.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_b("rerst_s_tready", bus.s_tready, 1'b1);
    nak_token();
    push_run(8'h66, 2, 1'b1);
    src_idle();
    token_pkt(1'b0);
    handshake(1'b1, 1'b0);
    cur_pkt.delete();

    check_b("sb_empty", sb.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
